// File: rtl/doorlock_seq_pkg.sv
// Shared definitions for the doorlock sequencer: datapath state codes, sequencer
// states and the state-to-datapath-code decode.
package doorlock_seq_pkg;

   localparam int unsigned DP_W   = 2;
   localparam int unsigned CODE_W = 4;

   localparam logic [DP_W-1:0] DL_IDLE  = 2'b00;
   localparam logic [DP_W-1:0] DL_LOAD  = 2'b01;
   localparam logic [DP_W-1:0] DL_CHECK = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ARMED   = 3'd2,
      S_CHECK   = 3'd3,
      S_OPEN    = 3'd4,
      S_LOCKOUT = 3'd5
   } seq_state_t;

   // Datapath state code presented while the sequencer sits in state s
   function automatic logic [DP_W-1:0] dp_code(input seq_state_t s);
      logic [DP_W-1:0] c;
      case (s)
         S_LOAD, S_ARMED: c = DL_LOAD;
         S_CHECK, S_OPEN: c = DL_CHECK;
         default:         c = DL_IDLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/doorlock_timer.sv
// Loadable down-counter; done_c pulses for one cycle when a loaded count
// reaches zero (load value N gives done_c N cycles after the load edge).
module doorlock_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done_c
);

   logic [CNT_W-1:0] cnt;
   logic             run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (load) begin
         cnt <= load_val;
         run <= 1'b1;
      end else if (run) begin
         if (cnt == '0) run <= 1'b0;
         else           cnt <= cnt - CNT_W'(1);
      end
   end

   assign done_c = run && (cnt == '0);

endmodule

// File: rtl/doorlock_seq.sv
// Keypad-to-datapath sequencer for the doorlock: load, check, timed unlock and
// failure lockout. Optional DOORLOCK_ARM_TIMEOUT_EN abandons an idle ARMED code.
module doorlock_seq
   import doorlock_seq_pkg::*;
#(
   parameter int unsigned MAX_FAIL    = 3,
   parameter int unsigned OPEN_CYC    = 500,
   parameter int unsigned LOCKOUT_CYC = 1000,
   parameter int unsigned CNT_W       = 16
`ifdef DOORLOCK_ARM_TIMEOUT_EN
   ,
   parameter int unsigned ARM_TIMEOUT = 2000
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_valid,
   input  logic [CODE_W-1:0] key_code,
   output logic              key_ready,
   input  logic              enter,
   input  logic              cancel,
   output logic [DP_W-1:0]   dp_state,
   output logic [CODE_W-1:0] dp_ps_num,
   input  logic              dp_door_open,
   output logic              unlock,
   output logic              locked_out,
   output logic [1:0]        fail_cnt,
   output logic              busy
);

   localparam logic [1:0]       MAX_F        = 2'(MAX_FAIL);
   localparam logic [CNT_W-1:0] OPEN_LOAD    = CNT_W'(OPEN_CYC - 1);
   localparam logic [CNT_W-1:0] LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CHECK_LOAD   = CNT_W'(1);
`ifdef DOORLOCK_ARM_TIMEOUT_EN
   localparam bit               ARM_TO_EN    = 1'b1;
   localparam logic [CNT_W-1:0] ARM_LOAD     = CNT_W'(ARM_TIMEOUT - 1);
`else
   localparam bit               ARM_TO_EN    = 1'b0;
   localparam logic [CNT_W-1:0] ARM_LOAD     = '0;
`endif

   seq_state_t       state, state_nxt;
   logic [1:0]       fail_nxt, fail_inc;
   logic             capture;
   logic             tmr_load, tmr_done;
   logic [CNT_W-1:0] tmr_val;

   doorlock_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done_c   (tmr_done)
   );

   assign fail_inc = (fail_cnt == MAX_F) ? fail_cnt : fail_cnt + 2'd1;

   // Next state, fail counter and timer reload on every state entry
   always_comb begin
      state_nxt = state;
      fail_nxt  = fail_cnt;
      capture   = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      case (state)
         S_IDLE: begin
            if (key_valid && key_ready) begin
               capture   = 1'b1;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD:  state_nxt = S_ARMED;
         S_ARMED: begin
            if (enter)                      state_nxt = S_CHECK;
            else if (cancel)                state_nxt = S_IDLE;
            else if (ARM_TO_EN && tmr_done) state_nxt = S_IDLE;
         end
         S_CHECK: begin
            if (tmr_done) begin
               if (dp_door_open) begin
                  fail_nxt  = 2'd0;
                  state_nxt = S_OPEN;
               end else begin
                  fail_nxt  = fail_inc;
                  state_nxt = (fail_inc == MAX_F) ? S_LOCKOUT : S_IDLE;
               end
            end
         end
         S_OPEN: if (tmr_done) state_nxt = S_IDLE;
         S_LOCKOUT: begin
            if (tmr_done) begin
               fail_nxt  = 2'd0;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      if (state_nxt != state) begin
         tmr_load = 1'b1;
         case (state_nxt)
            S_ARMED:   tmr_val = ARM_LOAD;
            S_CHECK:   tmr_val = CHECK_LOAD;
            S_OPEN:    tmr_val = OPEN_LOAD;
            S_LOCKOUT: tmr_val = LOCKOUT_LOAD;
            default:   tmr_val = '0;
         endcase
      end
   end

   // State and registered outputs decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         fail_cnt   <= 2'd0;
         dp_ps_num  <= '0;
         dp_state   <= DL_IDLE;
         key_ready  <= 1'b1;
         busy       <= 1'b0;
         unlock     <= 1'b0;
         locked_out <= 1'b0;
      end else begin
         state      <= state_nxt;
         fail_cnt   <= fail_nxt;
         if (capture) dp_ps_num <= key_code;
         dp_state   <= dp_code(state_nxt);
         key_ready  <= (state_nxt == S_IDLE);
         busy       <= (state_nxt != S_IDLE);
         unlock     <= (state_nxt == S_OPEN);
         locked_out <= (state_nxt == S_LOCKOUT);
      end
   end

endmodule

// File: tb/tb_doorlock_seq.sv
// Directed bench for doorlock_seq with a small doorlock datapath model
// (PASSWORD 4'b1101). Define DOORLOCK_ARM_TIMEOUT_EN to also cover the arm timeout.
module tb_doorlock_seq;

   localparam logic [3:0] PASSWORD = 4'b1101;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key_valid, enter, cancel;
   logic [3:0] key_code;
   logic       key_ready;
   logic [1:0] dp_state;
   logic [3:0] dp_ps_num;
   logic       dp_door_open;
   logic       unlock, locked_out, busy;
   logic [1:0] fail_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   doorlock_seq #(
      .MAX_FAIL    (3),
      .OPEN_CYC    (4),
      .LOCKOUT_CYC (8),
      .CNT_W       (16)
`ifdef DOORLOCK_ARM_TIMEOUT_EN
      ,
      .ARM_TIMEOUT (5)
`endif
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .key_ready    (key_ready),
      .enter        (enter),
      .cancel       (cancel),
      .dp_state     (dp_state),
      .dp_ps_num    (dp_ps_num),
      .dp_door_open (dp_door_open),
      .unlock       (unlock),
      .locked_out   (locked_out),
      .fail_cnt     (fail_cnt),
      .busy         (busy)
   );

   // Datapath model: latch the code while state is 01, open on a match in 10
   logic [3:0] dl_code;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                dl_code <= 4'd0;
      else if (dp_state == 2'b01) dl_code <= dp_ps_num;
   end
   assign dp_door_open = (dp_state == 2'b10) && (dl_code == PASSWORD);

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Handshake a code, press enter, and step to the cycle after the check decision
   task automatic do_attempt(input logic [3:0] code);
      key_valid = 1'b1; key_code = code;
      tick;
      key_valid = 1'b0;
      tick;
      enter = 1'b1;
      tick;
      enter = 1'b0;
      tick;
      tick;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0; enter = 1'b0; cancel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (dp_state !== 2'b00) $display("FAIL reset_dp_state got=%0h exp=0", dp_state); else n_pass++;
      n_chk++; if (key_ready !== 1'b1) $display("FAIL reset_key_ready got=%0b exp=1", key_ready); else n_pass++;
      n_chk++; if (unlock !== 1'b0) $display("FAIL reset_unlock got=%0b exp=0", unlock); else n_pass++;
      n_chk++; if (locked_out !== 1'b0) $display("FAIL reset_locked_out got=%0b exp=0", locked_out); else n_pass++;
      n_chk++; if (fail_cnt !== 2'd0) $display("FAIL reset_fail_cnt got=%0d exp=0", fail_cnt); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
      n_chk++; if (dp_ps_num !== 4'd0) $display("FAIL reset_dp_ps_num got=%0h exp=0", dp_ps_num); else n_pass++;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_open;
      key_valid = 1'b1; key_code = PASSWORD;
      tick;
      key_valid = 1'b0;
      n_chk++; if (dp_state !== 2'b01) $display("FAIL open_load_dp_state got=%0h exp=1", dp_state); else n_pass++;
      n_chk++; if (dp_ps_num !== PASSWORD) $display("FAIL open_load_ps_num got=%0h exp=d", dp_ps_num); else n_pass++;
      n_chk++; if (busy !== 1'b1) $display("FAIL open_load_busy got=%0b exp=1", busy); else n_pass++;
      tick;
      n_chk++; if (dp_state !== 2'b01) $display("FAIL open_armed_dp_state got=%0h exp=1", dp_state); else n_pass++;
      n_chk++; if (key_ready !== 1'b0) $display("FAIL open_armed_key_ready got=%0b exp=0", key_ready); else n_pass++;
      enter = 1'b1;
      tick;
      enter = 1'b0;
      n_chk++; if (dp_state !== 2'b10) $display("FAIL open_check1_dp_state got=%0h exp=2", dp_state); else n_pass++;
      tick;
      n_chk++; if (dp_state !== 2'b10) $display("FAIL open_check2_dp_state got=%0h exp=2", dp_state); else n_pass++;
      n_chk++; if (unlock !== 1'b0) $display("FAIL open_check2_unlock got=%0b exp=0", unlock); else n_pass++;
      tick;
      for (int i = 0; i < 4; i++) begin
         n_chk++; if (unlock !== 1'b1) $display("FAIL open_unlock_c%0d got=%0b exp=1", i + 1, unlock); else n_pass++;
         n_chk++; if (dp_state !== 2'b10) $display("FAIL open_dp_state_c%0d got=%0h exp=2", i + 1, dp_state); else n_pass++;
         tick;
      end
      n_chk++; if (unlock !== 1'b0) $display("FAIL open_end_unlock got=%0b exp=0", unlock); else n_pass++;
      n_chk++; if (key_ready !== 1'b1) $display("FAIL open_end_key_ready got=%0b exp=1", key_ready); else n_pass++;
      n_chk++; if (dp_state !== 2'b00) $display("FAIL open_end_dp_state got=%0h exp=0", dp_state); else n_pass++;
      n_chk++; if (fail_cnt !== 2'd0) $display("FAIL open_end_fail_cnt got=%0d exp=0", fail_cnt); else n_pass++;
   endtask

   task automatic test_lockout;
      for (int k = 1; k <= 3; k++) begin
         do_attempt(4'b0000);
         n_chk++; if (fail_cnt !== 2'(k)) $display("FAIL lock_fail_cnt_%0d got=%0d exp=%0d", k, fail_cnt, k); else n_pass++;
         n_chk++; if (locked_out !== (k == 3)) $display("FAIL lock_locked_out_%0d got=%0b exp=%0b", k, locked_out, k == 3); else n_pass++;
      end
      key_valid = 1'b1; key_code = PASSWORD;
      for (int i = 0; i < 8; i++) begin
         n_chk++; if (locked_out !== 1'b1) $display("FAIL lock_hold_c%0d got=%0b exp=1", i + 1, locked_out); else n_pass++;
         n_chk++; if (key_ready !== 1'b0 || dp_state !== 2'b00) $display("FAIL lock_idle_c%0d key_ready=%0b dp_state=%0h exp=0/0", i + 1, key_ready, dp_state); else n_pass++;
         tick;
      end
      n_chk++; if (locked_out !== 1'b0) $display("FAIL lock_end_locked_out got=%0b exp=0", locked_out); else n_pass++;
      n_chk++; if (fail_cnt !== 2'd0) $display("FAIL lock_end_fail_cnt got=%0d exp=0", fail_cnt); else n_pass++;
      n_chk++; if (dp_ps_num !== 4'b0000) $display("FAIL lock_end_ps_num got=%0h exp=0", dp_ps_num); else n_pass++;
      n_chk++; if (key_ready !== 1'b1) $display("FAIL lock_end_key_ready got=%0b exp=1", key_ready); else n_pass++;
      key_valid = 1'b0;
   endtask

   task automatic test_recover;
      do_attempt(4'b0111);
      n_chk++; if (fail_cnt !== 2'd1) $display("FAIL recover_fail1 got=%0d exp=1", fail_cnt); else n_pass++;
      do_attempt(4'b1100);
      n_chk++; if (fail_cnt !== 2'd2) $display("FAIL recover_fail2 got=%0d exp=2", fail_cnt); else n_pass++;
      do_attempt(PASSWORD);
      n_chk++; if (fail_cnt !== 2'd0) $display("FAIL recover_fail_clr got=%0d exp=0", fail_cnt); else n_pass++;
      n_chk++; if (unlock !== 1'b1) $display("FAIL recover_unlock got=%0b exp=1", unlock); else n_pass++;
      n_chk++; if (locked_out !== 1'b0) $display("FAIL recover_locked_out got=%0b exp=0", locked_out); else n_pass++;
      repeat (4) tick;
      n_chk++; if (key_ready !== 1'b1) $display("FAIL recover_idle got=%0b exp=1", key_ready); else n_pass++;
   endtask

   task automatic test_priority;
      key_valid = 1'b1; key_code = 4'b0000;
      tick;
      key_valid = 1'b0;
      tick;
      enter = 1'b1; cancel = 1'b1;
      tick;
      enter = 1'b0; cancel = 1'b0;
      n_chk++; if (dp_state !== 2'b10) $display("FAIL prio_check_dp_state got=%0h exp=2", dp_state); else n_pass++;
      tick;
      tick;
      n_chk++; if (fail_cnt !== 2'd1 || key_ready !== 1'b1) $display("FAIL prio_after_check fail_cnt=%0d key_ready=%0b exp=1/1", fail_cnt, key_ready); else n_pass++;
      key_valid = 1'b1; key_code = 4'b0011;
      tick;
      key_valid = 1'b0;
      tick;
      cancel = 1'b1;
      tick;
      cancel = 1'b0;
      n_chk++; if (dp_state !== 2'b00) $display("FAIL cancel_dp_state got=%0h exp=0", dp_state); else n_pass++;
      n_chk++; if (key_ready !== 1'b1) $display("FAIL cancel_key_ready got=%0b exp=1", key_ready); else n_pass++;
      n_chk++; if (fail_cnt !== 2'd1) $display("FAIL cancel_fail_cnt got=%0d exp=1", fail_cnt); else n_pass++;
      enter = 1'b1;
      tick;
      enter = 1'b0;
      n_chk++; if (dp_state !== 2'b00 || busy !== 1'b0) $display("FAIL idle_enter dp_state=%0h busy=%0b exp=0/0", dp_state, busy); else n_pass++;
      tick;
      n_chk++; if (busy !== 1'b0) $display("FAIL idle_enter_later busy=%0b exp=0", busy); else n_pass++;
   endtask

`ifdef DOORLOCK_ARM_TIMEOUT_EN
   task automatic test_arm_timeout;
      key_valid = 1'b1; key_code = PASSWORD;
      tick;
      key_valid = 1'b0;
      tick;
      for (int i = 0; i < 5; i++) begin
         n_chk++; if (dp_state !== 2'b01) $display("FAIL armto_armed_c%0d got=%0h exp=1", i + 1, dp_state); else n_pass++;
         tick;
      end
      n_chk++; if (dp_state !== 2'b00 || key_ready !== 1'b1) $display("FAIL armto_idle dp_state=%0h key_ready=%0b exp=0/1", dp_state, key_ready); else n_pass++;
      n_chk++; if (fail_cnt !== 2'd1) $display("FAIL armto_fail_cnt got=%0d exp=1", fail_cnt); else n_pass++;
   endtask
`endif

   task automatic test_reset_open;
      do_attempt(PASSWORD);
      tick;
      n_chk++; if (unlock !== 1'b1) $display("FAIL rst_open_pre_unlock got=%0b exp=1", unlock); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++; if (unlock !== 1'b0) $display("FAIL rst_open_unlock got=%0b exp=0", unlock); else n_pass++;
      n_chk++; if (dp_state !== 2'b00) $display("FAIL rst_open_dp_state got=%0h exp=0", dp_state); else n_pass++;
      rst_n = 1'b1;
      tick;
      n_chk++; if (key_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_open_idle key_ready=%0b busy=%0b exp=1/0", key_ready, busy); else n_pass++;
      n_chk++; if (unlock !== 1'b0 || fail_cnt !== 2'd0) $display("FAIL rst_open_after unlock=%0b fail_cnt=%0d exp=0/0", unlock, fail_cnt); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_open;
      test_lockout;
      test_recover;
      test_priority;
`ifdef DOORLOCK_ARM_TIMEOUT_EN
      test_arm_timeout;
`endif
      test_reset_open;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout after %0d checks", n_chk);
      $fatal(1, "watchdog");
   end

endmodule
